// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory stage for a single-cycle MIPS core.
//
// Provides a word RAM (combinational read, synchronous write) plus a small
// memory-mapped I/O window at MMIO_BASE:
//   +0x0 TXDATA  write pushes write_data_i32[7:0] into the TX FIFO, reads 0
//   +0x4 STATUS  read {16'b0, count[7:0], 5'b0, overflow, empty, full};
//                write with bit2 = 1 clears the sticky overflow flag
//   +0x8 CYCLE   free-running cycle counter; a write loads it
//   +0xC / unmapped: reads 0, writes ignored
// Address bits [1:0] are ignored; every access is a full word.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset (FIFO, overflow, counter)
//   addr_i32       byte address (core ALU output)
//   write_data_i32 store data
//   enable_wmem_i  store strobe, takes effect at the next rising edge
//   read_data_o32  load data, combinational from addr_i32 and current state
//   tx_data_o8     byte at the FIFO head
//   tx_valid_o     FIFO non-empty
//   tx_ready_i     consumer ready
//
// TX handshake: a byte transfers on a rising edge where tx_valid_o and
// tx_ready_i are both 1. While tx_valid_o is 1 and tx_ready_i is 0 the head
// byte and tx_valid_o hold. tx_valid_o never depends on tx_ready_i, and
// tx_data_o8 is meaningless while tx_valid_o is 0.

module dmem_mmio #(
  parameter int          RAM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  input  logic        enable_wmem_i,
  output logic [31:0] read_data_o32,
  output logic [7:0]  tx_data_o8,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);

  // Byte offset within a word plays no part in a word-only memory map.
  logic unused_addr;
  assign unused_addr = ^addr_i32[1:0];

  // ---------------------------------------------------------------- decode
  logic ram_hit, mmio_hit, txdata_hit, status_hit, cycle_hit;

  assign ram_hit    = addr_i32 < RAM_BYTES;
  assign mmio_hit   = addr_i32[31:4] == MMIO_BASE[31:4];
  assign txdata_hit = mmio_hit && (addr_i32[3:2] == 2'd0);
  assign status_hit = mmio_hit && (addr_i32[3:2] == 2'd1);
  assign cycle_hit  = mmio_hit && (addr_i32[3:2] == 2'd2);

  // ------------------------------------------------------------------- RAM
  logic [31:0]   ram [RAM_DEPTH];
  logic [AW-1:0] ram_idx;

  assign ram_idx = addr_i32[AW+1:2];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (enable_wmem_i && ram_hit) begin
      ram[ram_idx] <= write_data_i32;
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full, empty;
  logic          push_req, push, pop, ovf_set, ovf_clr;

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign pop      = tx_valid_o && tx_ready_i;
  assign push_req = enable_wmem_i && txdata_hit;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = enable_wmem_i && status_hit && write_data_i32[2];

  assign tx_valid_o = !empty;
  assign tx_data_o8 = fifo_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= write_data_i32[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Setting wins over clearing.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------- cycle counter
  logic [31:0] cycle;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycle <= '0;
    end else if (enable_wmem_i && cycle_hit) begin
      cycle <= write_data_i32;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // ------------------------------------------------------------ read mux
  always_comb begin
    read_data_o32 = '0;
    if (ram_hit) begin
      read_data_o32 = ram[ram_idx];
    end else if (status_hit) begin
      read_data_o32 = {16'b0, 8'(count), 5'b0, overflow, empty, full};
    end else if (cycle_hit) begin
      read_data_o32 = cycle;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam logic [31:0] TXD = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
  localparam logic [31:0] CYC = 32'hFFFF_0008;
  localparam int          DEPTH = 4;

  // ------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] addr_i32 = '0;
  logic [31:0] write_data_i32 = '0;
  logic        enable_wmem_i = 1'b0;
  logic [31:0] read_data_o32;
  logic [7:0]  tx_data_o8;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .addr_i32       (addr_i32),
    .write_data_i32 (write_data_i32),
    .enable_wmem_i  (enable_wmem_i),
    .read_data_o32  (read_data_o32),
    .tx_data_o8     (tx_data_o8),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i)
  );

  // ----------------------------------------------------------- scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------- driver task
  // One access per cycle: inputs change at the falling edge, combinational
  // outputs are settled 1 time unit later.
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy);
    @(negedge clk);
    enable_wmem_i  = we;
    addr_i32       = a;
    write_data_i32 = d;
    tx_ready_i     = rdy;
    if (we && a == TXD) begin
      if (exp_q.size() < DEPTH || (rdy && exp_q.size() > 0)) exp_q.push_back(d[7:0]);
    end
    #1;
  endtask

  // Monitor: a transfer seen mid-cycle happens at the next rising edge.
  always begin
    @(negedge clk);
    #3;
    if (!reset_i && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%h expected=none", tx_data_o8);
      end else begin
        check("tx_byte", {24'b0, tx_data_o8}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0014, 32'h0000_0000, 32'h0,          1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h0,          1'b1};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,          1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0,          1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h2222_2222, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'hCAFE_0000, 32'h0,          1'b0};
    vecs[10] = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 32'h0000_00FC, 32'h0,         32'h0BAD_F00D, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,          1'b1};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_0000, 1'b1};
    vecs[14] = '{1'b1, 32'hFFFF_000C, 32'h1234_5678, 32'h0,          1'b0};
    vecs[15] = '{1'b0, 32'hFFFF_000C, 32'h0,         32'h0,          1'b1};
    vecs[16] = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h0,          1'b1};
    vecs[17] = '{1'b0, 32'hFFFF_0010, 32'h0,         32'h0,          1'b1};
    vecs[18] = '{1'b1, 32'h4000_0010, 32'hFFFF_FFFF, 32'h0,          1'b0};
    vecs[19] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
  end

  // ------------------------------------------------------------ sequences
  initial begin
    // Reset and first reads.
    repeat (2) @(negedge clk);
    #1;
    check("valid_in_reset", {31'b0, tx_valid_o}, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (5) @(posedge clk);
    drive(1'b0, CYC, 32'h0, 1'b0);
    check("cycle_at_5", read_data_o32, 32'd5);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("status_reset", read_data_o32, 32'h0000_0002);
    check("valid_reset", {31'b0, tx_valid_o}, 32'h0);

    // RAM and decode vectors.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
      if (vecs[i].chk) check($sformatf("vec%0d", i), read_data_o32, vecs[i].exp);
    end

    // Fill, then overflow.
    for (int b = 8'h41; b <= 8'h44; b++) drive(1'b1, TXD, 32'(b), 1'b0);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("status_full", read_data_o32, 32'h0000_0401);
    drive(1'b1, TXD, 32'h45, 1'b0);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("status_ovf", read_data_o32, 32'h0000_0405);

    // Drain on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, STA, 32'h0, 1'b1);
      check("drain_valid", {31'b0, tx_valid_o}, 32'h1);
      check("drain_status", read_data_o32,
            {16'h0, 8'(4 - i), 5'b0, 1'b1, 1'b0, (i == 0)});
    end
    drive(1'b0, STA, 32'h0, 1'b0);
    check("drain_empty_valid", {31'b0, tx_valid_o}, 32'h0);
    check("drain_empty_status", read_data_o32, 32'h0000_0006);
    check("drain_all_seen", 32'(exp_q.size()), 32'h0);

    // Full FIFO with simultaneous push and pop; pointers wrap.
    for (int b = 8'h61; b <= 8'h64; b++) drive(1'b1, TXD, 32'(b), 1'b0);
    drive(1'b1, TXD, 32'h55, 1'b1);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("full_pushpop_status", read_data_o32, 32'h0000_0405);
    check("full_pushpop_head", {24'b0, tx_data_o8}, 32'h62);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, STA, 32'h0, 1'b1);
      check("wrap_valid", {31'b0, tx_valid_o}, 32'h1);
    end
    drive(1'b0, STA, 32'h0, 1'b0);
    check("wrap_empty_status", read_data_o32, 32'h0000_0006);
    check("wrap_all_seen", 32'(exp_q.size()), 32'h0);

    // Overflow clear: bit2 = 0 must not clear, bit2 = 1 must.
    drive(1'b1, STA, 32'hFFFF_FFFB, 1'b0);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("ovf_kept", read_data_o32, 32'h0000_0006);
    drive(1'b1, STA, 32'h0000_0004, 1'b0);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("ovf_cleared", read_data_o32, 32'h0000_0002);

    // Cycle counter load and wrap.
    drive(1'b1, CYC, 32'hFFFF_FFFE, 1'b0);
    drive(1'b0, CYC, 32'h0, 1'b0);
    check("cycle_loaded", read_data_o32, 32'hFFFF_FFFE);
    drive(1'b0, CYC, 32'h0, 1'b0);
    check("cycle_ffff", read_data_o32, 32'hFFFF_FFFF);
    drive(1'b0, CYC, 32'h0, 1'b0);
    check("cycle_wrap", read_data_o32, 32'h0000_0000);
    drive(1'b0, CYC, 32'h0, 1'b0);
    check("cycle_one", read_data_o32, 32'h0000_0001);

    // Reset in the middle of a drain, with overflow set.
    for (int b = 8'h71; b <= 8'h75; b++) drive(1'b1, TXD, 32'(b), 1'b0);
    drive(1'b0, STA, 32'h0, 1'b1);
    drive(1'b0, STA, 32'h0, 1'b1);
    check("pre_reset_valid", {31'b0, tx_valid_o}, 32'h1);
    #1;
    reset_i = 1'b1;
    #1;
    check("reset_async_valid", {31'b0, tx_valid_o}, 32'h0);
    check("reset_async_status", read_data_o32, 32'h0000_0002);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    drive(1'b0, STA, 32'h0, 1'b1);
    check("post_reset_status", read_data_o32, 32'h0000_0002);
    check("post_reset_valid", {31'b0, tx_valid_o}, 32'h0);

    // Push into empty FIFO: no same-cycle bypass, head at entry 0.
    drive(1'b1, TXD, 32'h81, 1'b0);
    check("no_bypass", {31'b0, tx_valid_o}, 32'h0);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("one_valid", {31'b0, tx_valid_o}, 32'h1);
    check("one_status", read_data_o32, 32'h0000_0100);
    check("one_head", {24'b0, tx_data_o8}, 32'h81);
    drive(1'b0, STA, 32'h0, 1'b1);
    drive(1'b0, STA, 32'h0, 1'b0);
    check("final_status", read_data_o32, 32'h0000_0002);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
